// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: request/response instruction fetch engine with a DEPTH-entry
// in-order fetch queue in front of decode. Every queue entry is reserved when
// its request is accepted, so the response path can never overflow. A PC
// redirect flushes the queue and counts the stale responses still in flight
// so they can be dropped silently when they return.
//
// Handshake: a request transfers on a rising clock edge where imem_req_valid
// and imem_req_ready are both high. imem_req_valid never waits on
// imem_req_ready, and imem_req_addr is stable while the request is pending.
// The response channel has no backpressure: every cycle with imem_rsp_valid
// high delivers exactly one response, in request order.
module cpu_fetch_queue #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BOOT_ADDR   = '0,
    parameter int unsigned            DEPTH       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_instr,
    input  logic                   change_PC,
    input  logic [ADDR_WIDTH-1:0]  new_PC,
    input  logic                   stall,
    output logic                   decode_valid,
    output logic [INSTR_WIDTH-1:0] decode_instr,
    output logic [ADDR_WIDTH-1:0]  decode_next_PC,
    output logic                   decode_nop
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    // Back-to-back redirects under a slow memory can stack more stale
    // responses than there are queue entries, so the discard counter gets
    // one extra bit of headroom.
    localparam int unsigned DISC_W = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_d [DEPTH];
    logic [ADDR_WIDTH-1:0]  next_pc_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  next_pc_d [DEPTH];
    logic [DEPTH-1:0]       filled_q, filled_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       fill_q, fill_d;
    logic [PTR_W-1:0]       alloc_q, alloc_d;
    logic [CNT_W-1:0]       alloc_count_q, alloc_count_d;
    logic [DISC_W-1:0]      discard_count_q, discard_count_d;

    logic                   req_fire;
    logic                   pop;
    logic [PTR_W-1:0]       ptr_gap;
    logic [CNT_W-1:0]       unfilled;
    logic [DISC_W-1:0]      discard_redirect;

    // Request and decode outputs; decode reads the registered head entry only.
    assign imem_req_valid = !reset && !change_PC && (alloc_count_q < CNT_W'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign decode_valid   = filled_q[head_q] && (alloc_count_q != '0) && !change_PC;
    assign decode_instr   = instr_q[head_q];
    assign decode_next_PC = next_pc_q[head_q];
    assign decode_nop     = change_PC;
    assign pop            = decode_valid && !stall;
    assign ptr_gap        = alloc_q - fill_q;

    // Allocated-but-unfilled entries; alloc == fill means either none or all of them.
    always_comb begin
        unfilled = CNT_W'(ptr_gap);
        if (alloc_q == fill_q) begin
            if ((alloc_count_q == CNT_W'(DEPTH)) && !filled_q[fill_q]) begin
                unfilled = CNT_W'(DEPTH);
            end else begin
                unfilled = '0;
            end
        end
    end

    // Every unfilled entry becomes a stale response; one returning now is already spent.
    assign discard_redirect = discard_count_q + DISC_W'(unfilled) - DISC_W'(imem_rsp_valid);

    // Next-state: redirect wins; otherwise pop, response fill and allocation combine.
    always_comb begin
        fetch_pc_d      = fetch_pc_q;
        instr_d         = instr_q;
        next_pc_d       = next_pc_q;
        filled_d        = filled_q;
        head_d          = head_q;
        fill_d          = fill_q;
        alloc_d         = alloc_q;
        alloc_count_d   = alloc_count_q;
        discard_count_d = discard_count_q;
        if (change_PC) begin
            fetch_pc_d      = new_PC;
            fill_d          = head_q;
            alloc_d         = head_q;
            alloc_count_d   = '0;
            filled_d        = '0;
            discard_count_d = discard_redirect;
        end else begin
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PTR_W'(1);
            end
            if (imem_rsp_valid) begin
                if (discard_count_q != '0) begin
                    discard_count_d = discard_count_q - DISC_W'(1);
                end else begin
                    instr_d[fill_q]  = imem_rsp_instr;
                    filled_d[fill_q] = 1'b1;
                    fill_d           = fill_q + PTR_W'(1);
                end
            end
            if (req_fire) begin
                next_pc_d[alloc_q] = fetch_pc_q + PC_STEP;
                filled_d[alloc_q]  = 1'b0;
                alloc_d            = alloc_q + PTR_W'(1);
                fetch_pc_d         = fetch_pc_q + PC_STEP;
            end
            alloc_count_d = alloc_count_q + CNT_W'(req_fire) - CNT_W'(pop);
        end
    end

    // State registers with synchronous reset; entries are cleared so decode reads zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q      <= BOOT_ADDR;
            instr_q         <= '{default: '0};
            next_pc_q       <= '{default: '0};
            filled_q        <= '0;
            head_q          <= '0;
            fill_q          <= '0;
            alloc_q         <= '0;
            alloc_count_q   <= '0;
            discard_count_q <= '0;
        end else begin
            fetch_pc_q      <= fetch_pc_d;
            instr_q         <= instr_d;
            next_pc_q       <= next_pc_d;
            filled_q        <= filled_d;
            head_q          <= head_d;
            fill_q          <= fill_d;
            alloc_q         <= alloc_d;
            alloc_count_q   <= alloc_count_d;
            discard_count_q <= discard_count_d;
        end
    end
endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Bench for cpu_fetch_queue: a queue-level model of the fetch stream checked
// against the DUT on every cycle, a latency-programmable memory, directed
// scenarios with literal expectations, and a second instance booting near the
// top of the address space to exercise PC wrap.
module tb_cpu_fetch_queue;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BOOT   = 32'h0000_0000;
    localparam logic [31:0] BOOT_W = 32'hFFFF_FFF8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- main instance ----------------
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_instr = '0;
    logic        change_PC, stall;
    logic [31:0] new_PC;
    logic        decode_valid, decode_nop;
    logic [31:0] decode_instr, decode_next_PC;

    cpu_fetch_queue #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .BOOT_ADDR(BOOT), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr),
        .change_PC(change_PC), .new_PC(new_PC), .stall(stall),
        .decode_valid(decode_valid), .decode_instr(decode_instr),
        .decode_next_PC(decode_next_PC), .decode_nop(decode_nop)
    );

    // ---------------- wrap instance ----------------
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_instr = '0;
    logic        w_dec_valid, w_dec_nop;
    logic [31:0] w_dec_instr, w_dec_next;
    logic        w_hs_pend = 1'b0;
    logic [31:0] w_addr_pend = '0;

    cpu_fetch_queue #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .BOOT_ADDR(BOOT_W), .DEPTH(DEPTH)) dut_w (
        .clock(clock), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_instr(w_rsp_instr),
        .change_PC(1'b0), .new_PC(32'h0), .stall(1'b0),
        .decode_valid(w_dec_valid), .decode_instr(w_dec_instr),
        .decode_next_PC(w_dec_next), .decode_nop(w_dec_nop)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    int hs_cnt   = 0;
    bit started  = 1'b0;
    bit w_log_en = 1'b0;

    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic        rsp_next_valid = 1'b0;
    logic [31:0] rsp_next_instr = '0;

    logic [31:0] log_next[$];
    logic [31:0] log_instr[$];
    logic [31:0] w_req_log[$];
    logic [31:0] w_dec_next_log[$];
    logic [31:0] w_dec_instr_log[$];

    // Model: allocated fetches in program order, each with its filled flag.
    logic [31:0] m_addr[$];
    bit          m_filled[$];
    logic [31:0] m_fetch = BOOT;
    int          m_disc  = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a * 32'd13 + 32'h0100_0003;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory for the main instance: apply the response chosen at the last negedge.
    always @(posedge clock) begin
        cyc++;
        started = 1'b1;
        #1;
        imem_rsp_valid = rsp_next_valid;
        imem_rsp_instr = rsp_next_instr;
    end

    // Memory bookkeeping: accept requests, flush on reset, pick next cycle's response.
    always @(negedge clock) begin
        if (reset) begin
            mem_addr_q.delete();
            mem_due_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cyc + mem_lat);
            hs_cnt++;
        end
        rsp_next_valid = 1'b0;
        rsp_next_instr = '0;
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc + 1) begin
            rsp_next_valid = 1'b1;
            rsp_next_instr = instr_of(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
    end

    // Single-cycle memory for the wrap instance.
    always @(posedge clock) begin
        #1;
        w_rsp_valid = w_hs_pend;
        w_rsp_instr = instr_of(w_addr_pend);
    end

    // Loggers: decode pops of the main instance, first requests/decodes of the wrap instance.
    always @(negedge clock) begin
        w_hs_pend   = w_req_valid;
        w_addr_pend = w_req_addr;
        if (decode_valid && !stall) begin
            log_next.push_back(decode_next_PC);
            log_instr.push_back(decode_instr);
        end
        if (w_log_en && !reset) begin
            if (w_req_valid && w_req_log.size() < 4) w_req_log.push_back(w_req_addr);
            if (w_dec_valid && w_dec_next_log.size() < 4) begin
                w_dec_next_log.push_back(w_dec_next);
                w_dec_instr_log.push_back(w_dec_instr);
            end
        end
    end

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clock) begin
        bit exp_rv, exp_dv, found;
        int unf;
        if (started) begin
            exp_rv = !reset && !change_PC && (m_addr.size() < DEPTH);
            exp_dv = (m_addr.size() > 0) && m_filled[0] && !change_PC;
            check("req_valid", imem_req_valid, exp_rv);
            if (exp_rv) check("req_addr", imem_req_addr, m_fetch);
            check("decode_valid", decode_valid, exp_dv);
            if (exp_dv) begin
                check("decode_instr", decode_instr, instr_of(m_addr[0]));
                check("decode_next_pc", decode_next_PC, m_addr[0] + 32'd4);
            end
            check("decode_nop", decode_nop, change_PC);

            if (reset) begin
                m_addr.delete();
                m_filled.delete();
                m_fetch = BOOT;
                m_disc  = 0;
            end else if (change_PC) begin
                unf = 0;
                foreach (m_filled[i]) if (!m_filled[i]) unf++;
                m_disc  = m_disc + unf - (imem_rsp_valid ? 1 : 0);
                m_fetch = new_PC;
                m_addr.delete();
                m_filled.delete();
            end else begin
                if (imem_rsp_valid) begin
                    if (m_disc > 0) begin
                        m_disc--;
                    end else begin
                        found = 1'b0;
                        foreach (m_filled[i]) begin
                            if (!found && !m_filled[i]) begin
                                m_filled[i] = 1'b1;
                                found = 1'b1;
                            end
                        end
                        check("rsp_has_slot", found, 1'b1);
                    end
                end
                if (exp_dv && !stall) begin
                    void'(m_addr.pop_front());
                    void'(m_filled.pop_front());
                end
                if (exp_rv && imem_req_ready) begin
                    m_addr.push_back(m_fetch);
                    m_filled.push_back(1'b0);
                    m_fetch = m_fetch + 32'd4;
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        int hs_base, lb;
        imem_req_ready = 1'b1;
        change_PC      = 1'b0;
        new_PC         = '0;
        stall          = 1'b0;
        repeat (3) tick();

        // Reset values.
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_decode_valid", decode_valid, 1'b0);
        check("rst_decode_nop", decode_nop, 1'b0);
        check("rst_decode_instr", decode_instr, 32'h0);
        check("rst_decode_next_pc", decode_next_PC, 32'h0);

        // Release: first request to BOOT_ADDR in the same cycle.
        reset    = 1'b0;
        w_log_en = 1'b1;
        lb       = log_next.size();
        hs_base  = hs_cnt;
        #1;
        check("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, 32'h0);

        // Steady stream, 1-cycle memory: decodes start two cycles after release.
        repeat (10) tick();
        check("steady_accepts", hs_cnt - hs_base, 10);
        check("steady_decodes", log_next.size() - lb, 8);
        check("steady_first_next", qget(log_next, lb), 32'h4);
        check("steady_first_instr", qget(log_instr, lb), instr_of(32'h0));
        check("steady_third_next", qget(log_next, lb + 2), 32'hC);
        check("steady_last_next", qget(log_next, lb + 7), 32'h20);

        // Wrap instance: addresses and next_PC roll over to zero.
        check("wrap_req0", qget(w_req_log, 0), 32'hFFFF_FFF8);
        check("wrap_req1", qget(w_req_log, 1), 32'hFFFF_FFFC);
        check("wrap_req2", qget(w_req_log, 2), 32'h0000_0000);
        check("wrap_dec0_next", qget(w_dec_next_log, 0), 32'hFFFF_FFFC);
        check("wrap_dec1_next", qget(w_dec_next_log, 1), 32'h0000_0000);
        check("wrap_dec1_instr", qget(w_dec_instr_log, 1), instr_of(32'hFFFF_FFFC));

        // Memory not ready for 3 cycles: address held, queue drains.
        imem_req_ready = 1'b0;
        hs_base = hs_cnt;
        #1;
        check("nrdy_addr_c0", imem_req_addr, 32'h28);
        tick();
        check("nrdy_addr_c1", imem_req_addr, 32'h28);
        tick();
        check("nrdy_addr_c2", imem_req_addr, 32'h28);
        check("nrdy_drained", decode_valid, 1'b0);
        tick();
        check("nrdy_no_alloc", hs_cnt - hs_base, 0);

        // Stall 6 cycles from empty: exactly DEPTH accepts, head holds.
        imem_req_ready = 1'b1;
        stall   = 1'b1;
        hs_base = hs_cnt;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i == 2) begin
                check("stall_head_valid", decode_valid, 1'b1);
                check("stall_head_instr_early", decode_instr, instr_of(32'h28));
            end
            if (i == 5) begin
                check("stall_full_req_valid", imem_req_valid, 1'b0);
                check("stall_head_instr_late", decode_instr, instr_of(32'h28));
            end
            tick();
        end
        check("stall_accepts", hs_cnt - hs_base, DEPTH);
        stall = 1'b0;
        lb    = log_next.size();
        repeat (4) tick();
        check("unstall_burst", log_next.size() - lb, 4);
        check("unstall_first_next", qget(log_next, lb), 32'h2C);
        check("unstall_last_next", qget(log_next, lb + 3), 32'h38);
        check("unstall_last_instr", qget(log_instr, lb + 3), instr_of(32'h34));

        // Redirect with three fetches in flight.
        imem_req_ready = 1'b0;
        repeat (8) tick();
        mem_lat = 4;
        imem_req_ready = 1'b1;
        repeat (3) tick();
        change_PC = 1'b1;
        new_PC    = 32'h100;
        lb        = log_next.size();
        #1;
        check("redir_nop", decode_nop, 1'b1);
        check("redir_decode_valid", decode_valid, 1'b0);
        check("redir_req_valid", imem_req_valid, 1'b0);
        tick();
        change_PC = 1'b0;
        #1;
        check("redir_next_req_valid", imem_req_valid, 1'b1);
        check("redir_next_req_addr", imem_req_addr, 32'h100);
        repeat (8) tick();
        check("redir_decodes", log_next.size() - lb, 3);
        check("redir_first_next", qget(log_next, lb), 32'h104);
        check("redir_first_instr", qget(log_instr, lb), instr_of(32'h100));

        // Redirect coincident with a response and a would-be pop.
        imem_req_ready = 1'b0;
        repeat (8) tick();
        mem_lat = 2;
        imem_req_ready = 1'b1;
        repeat (3) tick();
        change_PC = 1'b1;
        new_PC    = 32'h200;
        lb        = log_next.size();
        #1;
        check("coinc_nop", decode_nop, 1'b1);
        check("coinc_decode_valid", decode_valid, 1'b0);
        tick();
        change_PC = 1'b0;
        #1;
        check("coinc_next_req_addr", imem_req_addr, 32'h200);
        repeat (6) tick();
        check("coinc_decodes", log_next.size() - lb, 3);
        check("coinc_first_next", qget(log_next, lb), 32'h204);
        check("coinc_first_instr", qget(log_instr, lb), instr_of(32'h200));

        // Reset with a full queue.
        mem_lat = 1;
        stall   = 1'b1;
        repeat (6) tick();
        check("full_head_valid", decode_valid, 1'b1);
        check("full_req_valid", imem_req_valid, 1'b0);
        reset = 1'b1;
        tick();
        check("mrst_req_valid", imem_req_valid, 1'b0);
        check("mrst_decode_valid", decode_valid, 1'b0);
        check("mrst_decode_nop", decode_nop, 1'b0);
        check("mrst_decode_instr", decode_instr, 32'h0);
        check("mrst_decode_next_pc", decode_next_PC, 32'h0);
        reset = 1'b0;
        stall = 1'b0;
        #1;
        check("mrst_req_valid_after", imem_req_valid, 1'b1);
        check("mrst_req_addr_after", imem_req_addr, BOOT);
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
